// File: rtl/pipelined_adder_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder_subtractor
//  Purpose  : Carry-pipelined adder/subtractor. The operand word is split into
//             STAGE_WIDTH-bit chunks and one chunk is resolved per pipeline
//             stage. The carry is registered between stages. Throughput is one
//             operation per cycle. Latency is NUM_STAGES register stages.
//  Ports    : CLK, RST          clock / synchronous active-high reset
//             IN_VALID/IN_READY input handshake (A, B, Cin, MODE)
//             OUT_VALID/OUT_READY output handshake (S, CF, OF, ZF, NF)
//             MODE 0 = ADD (A+B+Cin), 1 = SUB (A-B-Cin)
//             CF: carry-out (ADD) or borrow-out (SUB)
//             OF: signed overflow; ZF: S==0; NF: S MSB
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_adder_subtractor #(
    parameter int DATA_WIDTH  = 8,
    parameter int STAGE_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Cin,
    input  logic                  MODE,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] S,
    output logic                  CF,
    output logic                  OF,
    output logic                  ZF,
    output logic                  NF
);

    // Guarded so that a bad STAGE_WIDTH does not also raise a divide-by-zero.
    localparam int NUM_STAGES = (STAGE_WIDTH >= 1) ? (DATA_WIDTH / STAGE_WIDTH) : 1;
    localparam int LAST       = NUM_STAGES - 1;

    generate
        if (STAGE_WIDTH < 1) begin : g_bad_stage_width
            $error("pipelined_adder_subtractor: STAGE_WIDTH must be >= 1");
        end else if ((DATA_WIDTH % STAGE_WIDTH) != 0) begin : g_bad_data_width
            $error("pipelined_adder_subtractor: DATA_WIDTH must be a multiple of STAGE_WIDTH");
        end
    endgenerate

    // The whole pipe moves together. If the output is held, every stage
    // holds, so bubbles are never collapsed.
    logic adv;
    assign adv      = ~OUT_VALID | OUT_READY;
    assign IN_READY = adv;

    // Stage registers. Stage k holds the result bits resolved so far in st_s.
    // It also holds the carry out of chunk k. The still-unprocessed upper
    // operand bits travel alongside in st_a/st_b. B is already inverted for
    // SUB.
    logic                  st_valid [NUM_STAGES];
    logic                  st_mode  [NUM_STAGES];
    logic                  st_carry [NUM_STAGES];
    logic [DATA_WIDTH-1:0] st_a     [NUM_STAGES];
    logic [DATA_WIDTH-1:0] st_b     [NUM_STAGES];
    logic [DATA_WIDTH-1:0] st_s     [NUM_STAGES];

    // Stage inputs. Stage 0 takes them from the ports. Stage k takes them from
    // the registers of stage k-1.
    logic                  in_valid_k [NUM_STAGES];
    logic                  in_mode    [NUM_STAGES];
    logic                  in_cin     [NUM_STAGES];
    logic [DATA_WIDTH-1:0] in_a       [NUM_STAGES];
    logic [DATA_WIDTH-1:0] in_b       [NUM_STAGES];
    logic [DATA_WIDTH-1:0] in_s       [NUM_STAGES];

    // Combinational results of each stage's chunk addition.
    logic [DATA_WIDTH-1:0] nx_s     [NUM_STAGES];
    logic                  nx_carry [NUM_STAGES];
    logic                  nx_cmsb  [NUM_STAGES];

    // The flags are registered beside S so that they reset to 0. Deriving ZF
    // from a zero S would otherwise read 1 out of reset.
    logic cf_q;
    logic of_q;
    logic zf_q;
    logic nf_q;

    always_comb begin
        // SUB is A + ~B + ~Cin. Both inversions are applied on entry.
        in_valid_k[0] = IN_VALID;
        in_mode[0]    = MODE;
        in_cin[0]     = Cin ^ MODE;
        in_a[0]       = A;
        in_b[0]       = B ^ {DATA_WIDTH{MODE}};
        in_s[0]       = '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            in_valid_k[k] = st_valid[k-1];
            in_mode[k]    = st_mode[k-1];
            in_cin[k]     = st_carry[k-1];
            in_a[k]       = st_a[k-1];
            in_b[k]       = st_b[k-1];
            in_s[k]       = st_s[k-1];
        end
    end

    always_comb begin : chunk_add
        logic c;
        logic cm;
        int   idx;
        c   = 1'b0;
        cm  = 1'b0;
        idx = 0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            c       = in_cin[k];
            cm      = c;
            nx_s[k] = in_s[k];
            for (int i = 0; i < STAGE_WIDTH; i++) begin
                idx = k * STAGE_WIDTH + i;
                // cm ends up as the carry into the chunk MSB. This is the
                // carry into the word MSB for the last stage.
                cm            = c;
                nx_s[k][idx]  = in_a[k][idx] ^ in_b[k][idx] ^ c;
                c             = (in_a[k][idx] & in_b[k][idx]) |
                                (c & (in_a[k][idx] ^ in_b[k][idx]));
            end
            nx_carry[k] = c;
            nx_cmsb[k]  = cm;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                st_valid[k] <= 1'b0;
                st_mode[k]  <= 1'b0;
                st_carry[k] <= 1'b0;
                st_a[k]     <= '0;
                st_b[k]     <= '0;
                st_s[k]     <= '0;
            end
            cf_q <= 1'b0;
            of_q <= 1'b0;
            zf_q <= 1'b0;
            nf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                st_valid[k] <= in_valid_k[k];
                st_mode[k]  <= in_mode[k];
                st_carry[k] <= nx_carry[k];
                st_a[k]     <= in_a[k];
                st_b[k]     <= in_b[k];
                st_s[k]     <= nx_s[k];
            end
            // The raw carry-out of the inverted-B sum is "no borrow".
            cf_q <= nx_carry[LAST] ^ in_mode[LAST];
            of_q <= nx_carry[LAST] ^ nx_cmsb[LAST];
            zf_q <= (nx_s[LAST] == '0);
            nf_q <= nx_s[LAST][DATA_WIDTH-1];
        end
    end

    assign OUT_VALID = st_valid[LAST];
    assign S         = st_s[LAST];
    assign CF        = cf_q;
    assign OF        = of_q;
    assign ZF        = zf_q;
    assign NF        = nf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_adder_subtractor
//  Purpose  : Directed scoreboard bench for pipelined_adder_subtractor
//             (DATA_WIDTH=8, STAGE_WIDTH=4, two-cycle latency).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_adder_subtractor;

    localparam int DW  = 8;
    localparam int SW  = 4;
    localparam int LAT = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          Cin;
    logic          MODE;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [DW-1:0] S;
    logic          CF;
    logic          OF;
    logic          ZF;
    logic          NF;

    pipelined_adder_subtractor #(
        .DATA_WIDTH  (DW),
        .STAGE_WIDTH (SW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .MODE      (MODE),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .S         (S),
        .CF        (CF),
        .OF        (OF),
        .ZF        (ZF),
        .NF        (NF)
    );

    always #5 CLK = ~CLK;

    // Expected result: S, flags {CF,OF,ZF,NF}, and required output cycle (-1 = untimed).
    typedef struct {
        logic [DW-1:0] s;
        logic [3:0]    f;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Expected values for the op currently driven.
    logic          push_en;
    logic [DW-1:0] p_s;
    logic [3:0]    p_f;
    logic          p_timed;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: retire one expected entry per output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && OUT_VALID && OUT_READY) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output actual S=%0h required none (cycle %0d)", S, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("result{S,CF,OF,ZF,NF}", {52'd0, S, CF, OF, ZF, NF}, {52'd0, e.s, e.f});
                    if (e.cyc >= 0) chk("output_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // One clock: record an accepted op, then advance to just after the edge.
    task automatic tick();
        exp_t e;
        @(negedge CLK);
        if (IN_VALID && IN_READY && !RST && push_en) begin
            e.s   = p_s;
            e.f   = p_f;
            e.cyc = p_timed ? cyc + LAT : -1;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic mode, input logic [7:0] s, input logic [3:0] f,
                         input logic timed);
        IN_VALID = 1'b1;
        A        = a;
        B        = b;
        Cin      = cin;
        MODE     = mode;
        p_s      = s;
        p_f      = f;
        p_timed  = timed;
        tick();
    endtask

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
        A = '0; B = '0; Cin = 1'b0; MODE = 1'b0;
        push_en = 1'b1; p_s = '0; p_f = '0; p_timed = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        #1;
        // Reset state. IN_READY must be 1 even with OUT_READY low.
        chk("reset_out_valid", OUT_VALID, 0);
        chk("reset_S", S, 0);
        chk("reset_flags", {CF, OF, ZF, NF}, 0);
        chk("reset_in_ready", IN_READY, 1);
        OUT_READY = 1'b1;

        // Flags are ordered {CF,OF,ZF,NF}.
        drive(8'h7F, 8'h01, 0, 0, 8'h80, 4'b0101, 1);
        IN_VALID = 1'b0;
        #1;
        chk("no_early_valid", OUT_VALID, 0);
        idle(3);
        drive(8'hFF, 8'h01, 0, 0, 8'h00, 4'b1010, 1); idle(3);
        drive(8'h05, 8'h07, 0, 1, 8'hFE, 4'b1001, 1); idle(3);
        drive(8'h80, 8'h01, 0, 1, 8'h7F, 4'b0100, 1); idle(3);

        // Back-to-back: results must come out on consecutive cycles, in order.
        drive(8'h0F, 8'h01, 0, 0, 8'h10, 4'b0000, 1);
        drive(8'h3C, 8'h44, 1, 0, 8'h81, 4'b0101, 1);
        drive(8'h10, 8'h01, 1, 1, 8'h0E, 4'b0000, 1);
        drive(8'h00, 8'h00, 1, 1, 8'hFF, 4'b1001, 1);
        drive(8'h55, 8'h55, 0, 1, 8'h00, 4'b0010, 1);
        drive(8'h80, 8'h80, 0, 0, 8'h00, 4'b1110, 1);
        drive(8'h7F, 8'hFF, 0, 1, 8'h80, 4'b1101, 1);
        drive(8'h12, 8'h34, 1, 0, 8'h47, 4'b0000, 1);
        drive(8'h8F, 8'h10, 0, 1, 8'h7F, 4'b0100, 1);
        idle(4);

        // Backpressure with a full pipe. An op offered during the stall must be ignored.
        OUT_READY = 1'b0;
        drive(8'h12, 8'h34, 0, 0, 8'h46, 4'b0000, 0);
        drive(8'h20, 8'h30, 0, 1, 8'hF0, 4'b1001, 0);
        A = 8'hAA; B = 8'h55; Cin = 1'b0; MODE = 1'b0; p_s = 8'hEE; p_f = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", IN_READY, 0);
            chk("stall_out_valid", OUT_VALID, 1);
            chk("stall_S_frozen", {S, CF, OF, ZF, NF}, {8'h46, 4'b0000});
            tick();
        end
        OUT_READY = 1'b1;
        drive(8'h01, 8'h01, 1, 0, 8'h03, 4'b0000, 0);
        idle(4);

        // Reset with two ops in flight. Neither op may emerge.
        OUT_READY = 1'b0;
        push_en   = 1'b0;
        drive(8'h11, 8'h22, 0, 0, 8'h33, 4'b0000, 0);
        drive(8'h44, 8'h22, 0, 1, 8'h22, 4'b0000, 0);
        IN_VALID = 1'b0;
        RST      = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("midreset_out_valid", OUT_VALID, 0);
        chk("midreset_S", S, 0);
        chk("midreset_flags", {CF, OF, ZF, NF}, 0);
        chk("midreset_in_ready", IN_READY, 1);
        push_en   = 1'b1;
        OUT_READY = 1'b1;
        idle(5);
        drive(8'hFF, 8'hFF, 1, 0, 8'hFF, 4'b1001, 1);
        idle(1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
